mux2_src_ctrl: RTL and testbench
================================

# mux2_src_ctrl

Source controller placed directly upstream of the 8-bit 2:1 multiplexer in the element-experiment design. It captures two 8-bit operands from the board switches under debounced load buttons and drives the multiplexer's `I0`, `I1` and `s` inputs. The select line can be toggled manually by a debounced button, or alternated automatically at a fixed cycle interval. A one-cycle update strobe tells downstream logic when the multiplexer inputs have changed.

## Interface
- `DB_CYCLES`, default 4: number of consecutive cycles a synchronized button level must hold before it is accepted. Legal range is 2..65535.
- `ALT_DIV`, default 8: number of cycles between select toggles in auto mode. Legal range is 2..65535.
- `clk`  in  1: single clock; everything is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `sw`  in  8: switch data; asynchronous to `clk`.
- `ld0`  in  1: raw button; loads `sw` into `I0`.
- `ld1`  in  1: raw button; loads `sw` into `I1`.
- `btn_sel`  in  1: raw button; toggles `s` in manual mode.
- `auto_en`  in  1: raw switch; 1 selects auto-alternate mode.
- `I0`  out  8: multiplexer input 0; registered.
- `I1`  out  8: multiplexer input 1; registered.
- `s`  out  1: multiplexer select; registered.
- `upd`  out  1: one-cycle strobe, high in the first cycle in which any of `I0`, `I1`, `s` shows a new value.

## Operation
- Input conditioning:
  - `sw`, `ld0`, `ld1`, `btn_sel` and `auto_en` each pass through a 2-flop synchronizer.
  - `ld0`, `ld1` and `btn_sel` then pass through independent debouncers. Each debouncer has a 16-bit counter.
  - The counter clears whenever the synchronized level equals the debounced level.
  - When the levels differ for DB_CYCLES consecutive cycles, the debounced level flips and the counter clears.
  - A 0->1 flip of a debounced level produces a one-cycle press pulse. A 1->0 flip produces nothing.
- Operand load:
  - A `ld0` pulse writes the synchronized `sw` into `I0`. A `ld1` pulse writes it into `I1`.
  - Simultaneous `ld0` and `ld1` pulses load the same value into both registers.
  - A load whose value equals the current register content still asserts `upd`.
- Mode FSM has two states, MANUAL and AUTO. Reset enters MANUAL.
  - MANUAL->AUTO when synchronized `auto_en` = 1.
  - AUTO->MANUAL when synchronized `auto_en` = 0.
  - MANUAL: a `btn_sel` pulse inverts `s`. The alternation counter is held at 0.
  - AUTO: the alternation counter counts 0..ALT_DIV-1. At ALT_DIV-1, `s` inverts and the counter wraps to 0.
  - AUTO: `btn_sel` pulses are ignored, though the debouncer still tracks the button level.
  - On AUTO->MANUAL, `s` keeps its current value and the counter clears.
- Simultaneous events: a load and a select toggle in the same cycle both take effect, and produce a single `upd` pulse.
- Reset:
  - Values: `I0` = 0, `I1` = 0, `s` = 0, `upd` = 0, state MANUAL. All synchronizer flops, debounced levels and counters go to 0.
  - Reset overrides every other event in the same cycle.
  - A button still held when `rst` deasserts is debounced again from level 0. It therefore produces one press pulse after the normal latency.

## Timing
- Let edge t be the first clock edge at which the first synchronizer flop captures a new raw button level, with the raw level held stable afterwards.
- The debounced level flips at edge t+1+DB_CYCLES.
- The press pulse is high in the cycle that follows.
- The affected output register and `upd` update at edge t+2+DB_CYCLES.
- With the default DB_CYCLES = 4, the output changes 6 edges after capture.
- The sampled `sw` value is the synchronized value in the pulse cycle. `sw` must be stable for at least 3 cycles before the press.
- A bounce whose synchronized level lasts fewer than DB_CYCLES cycles produces no pulse and no output change.
- `auto_en` mode-change latency: 2 cycles of synchronization, then 1 cycle for the FSM state to change.
- First auto toggle: after entering AUTO, the first `s` toggle occurs ALT_DIV edges after the state change. `s` then toggles every ALT_DIV cycles.
- `upd` is exactly one cycle wide per update event. It is never asserted while `rst` = 1.

## Test plan
- Reset, then `sw` = 8'h55, `ld0` held high. `I0` = 8'h55 and `upd` = 1 exactly 6 edges after capture (DB_CYCLES = 4). `I1` = 0 and `s` = 0 remain unchanged.
- Bounce and clean press:
  - `ld1` high for 2 cycles, low for 2, high for 3, then low, with `sw` = 8'hAA. `I1` stays 0 and there is no `upd`.
  - A subsequent clean 10-cycle press gives `I1` = 8'hAA.
- MANUAL select:
  - Three clean `btn_sel` presses give `s` = 1, 0, 1, each change accompanied by one `upd`.
  - Holding `btn_sel` for 50 cycles counts as one toggle only.
- AUTO alternation (ALT_DIV = 8):
  - Raise `auto_en`. `s` toggles every 8 cycles for 5 periods, and `upd` pulses each time.
  - `btn_sel` presses in this period cause no extra toggles.
  - Drop `auto_en`. `s` freezes at its current value.
- Simultaneous load and reset:
  - Press `ld0` and `ld1` together with `sw` = 8'h3C. Both registers read 8'h3C, with a single `upd`.
  - Assert `rst` for 1 cycle mid-press while `ld0` stays held. All outputs are 0, then `I0` reloads 8'h3C after 6 edges.

Source files
------------

// File: rtl/mux2_src_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_src_ctrl
//  Purpose  : Source controller for the 8-bit 2:1 multiplexer experiment.
//             Two operands are captured from the board switches under
//             debounced load buttons. The select line is either toggled by a
//             debounced button (MANUAL) or alternated every ALT_DIV cycles
//             (AUTO). A one-cycle strobe marks every change of I0/I1/s.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DB_CYCLES : cycles a synchronized button level must persist (2..65535)
//    ALT_DIV   : cycles between select toggles in AUTO mode     (2..65535)
//  Ports
//    clk      in   1  rising-edge clock
//    rst      in   1  synchronous active-high reset
//    sw       in   8  switch data, asynchronous
//    ld0      in   1  raw button, loads sw into I0
//    ld1      in   1  raw button, loads sw into I1
//    btn_sel  in   1  raw button, toggles s in MANUAL mode
//    auto_en  in   1  raw switch, 1 = AUTO alternate mode
//    I0       out  8  multiplexer input 0 (registered)
//    I1       out  8  multiplexer input 1 (registered)
//    s        out  1  multiplexer select (registered)
//    upd      out  1  one-cycle strobe in the first cycle showing new outputs
// ============================================================================
module mux2_src_ctrl #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned ALT_DIV   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       ld0,
  input  logic       ld1,
  input  logic       btn_sel,
  input  logic       auto_en,
  output logic [7:0] I0,
  output logic [7:0] I1,
  output logic       s,
  output logic       upd
);

  // Button lane indices inside the packed button vectors.
  localparam int unsigned C_NUM_BTN = 3;
  localparam int unsigned C_BTN_LD0 = 0;
  localparam int unsigned C_BTN_LD1 = 1;
  localparam int unsigned C_BTN_SEL = 2;

  // The debounce counter reaching DB_CYCLES-1 while the levels still differ
  // means this is the DB_CYCLES-th consecutive differing cycle.
  localparam logic [15:0] C_DB_LAST  = 16'(DB_CYCLES - 1);
  localparam logic [15:0] C_ALT_LAST = 16'(ALT_DIV - 1);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } mode_e;

  // --------------------------------------------------------------------------
  // Two-flop synchronizers
  // --------------------------------------------------------------------------
  logic [7:0]           sw_s1_q,   sw_s1_d;
  logic [7:0]           sw_s2_q,   sw_s2_d;
  logic [C_NUM_BTN-1:0] btn_s1_q,  btn_s1_d;
  logic [C_NUM_BTN-1:0] btn_s2_q,  btn_s2_d;
  logic                 auto_s1_q, auto_s1_d;
  logic                 auto_s2_q, auto_s2_d;

  always_comb begin
    sw_s1_d   = sw;
    sw_s2_d   = sw_s1_q;
    btn_s1_d  = {btn_sel, ld1, ld0};
    btn_s2_d  = btn_s1_q;
    auto_s1_d = auto_en;
    auto_s2_d = auto_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q   <= 8'h00;
      sw_s2_q   <= 8'h00;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
    end else begin
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      auto_s1_q <= auto_s1_d;
      auto_s2_q <= auto_s2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Debouncers, one per button. Each yields a registered one-cycle press
  // pulse on a 0->1 flip of its debounced level; the pulse is visible in the
  // cycle right after the flip edge.
  // --------------------------------------------------------------------------
  logic [C_NUM_BTN-1:0] w_press;

  for (genvar gi = 0; gi < C_NUM_BTN; gi++) begin : g_debounce
    logic        lvl_q,   lvl_d;
    logic [15:0] cnt_q,   cnt_d;
    logic        press_q, press_d;

    always_comb begin
      lvl_d   = lvl_q;
      cnt_d   = 16'd0;
      press_d = 1'b0;
      if (btn_s2_q[gi] != lvl_q) begin
        if (cnt_q == C_DB_LAST) begin
          lvl_d   = ~lvl_q;
          // Only a rising debounced level counts as a press.
          press_d = ~lvl_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lvl_q   <= 1'b0;
        cnt_q   <= 16'd0;
        press_q <= 1'b0;
      end else begin
        lvl_q   <= lvl_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    assign w_press[gi] = press_q;
  end

  // --------------------------------------------------------------------------
  // Mode FSM and alternation counter
  // --------------------------------------------------------------------------
  mode_e       state_q,   state_d;
  logic [15:0] alt_cnt_q, alt_cnt_d;
  logic        w_auto_tog;
  logic        w_man_tog;

  always_comb begin
    state_d    = state_q;
    alt_cnt_d  = 16'd0;
    w_auto_tog = 1'b0;
    w_man_tog  = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        // Counter stays at 0 so the first AUTO toggle is ALT_DIV edges
        // after the mode change.
        w_man_tog = w_press[C_BTN_SEL];
        if (auto_s2_q) begin
          state_d = ST_AUTO;
        end
      end
      ST_AUTO: begin
        // Select-button presses are dropped here; leaving AUTO freezes s
        // and clears the counter without a final toggle.
        if (!auto_s2_q) begin
          state_d = ST_MANUAL;
        end else if (alt_cnt_q == C_ALT_LAST) begin
          w_auto_tog = 1'b1;
        end else begin
          alt_cnt_d = alt_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output registers and update strobe
  // --------------------------------------------------------------------------
  logic [7:0] i0_q,  i0_d;
  logic [7:0] i1_q,  i1_d;
  logic       s_q,   s_d;
  logic       upd_q, upd_d;
  logic       w_toggle;

  always_comb begin
    i0_d     = i0_q;
    i1_d     = i1_q;
    w_toggle = w_man_tog | w_auto_tog;
    s_d      = s_q ^ w_toggle;
    // Loads strobe even when the value does not change; simultaneous events
    // merge into a single strobe.
    upd_d    = w_press[C_BTN_LD0] | w_press[C_BTN_LD1] | w_toggle;
    if (w_press[C_BTN_LD0]) begin
      i0_d = sw_s2_q;
    end
    if (w_press[C_BTN_LD1]) begin
      i1_d = sw_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_MANUAL;
      alt_cnt_q <= 16'd0;
      i0_q      <= 8'h00;
      i1_q      <= 8'h00;
      s_q       <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alt_cnt_q <= alt_cnt_d;
      i0_q      <= i0_d;
      i1_q      <= i1_d;
      s_q       <= s_d;
      upd_q     <= upd_d;
    end
  end

  assign I0  = i0_q;
  assign I1  = i1_q;
  assign s   = s_q;
  assign upd = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_mux2_src_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux2_src_ctrl
//  Purpose  : Self-checking bench for mux2_src_ctrl. Directed vectors with
//             fixed expected results plus randomized stimulus, with a
//             cycle-level behavioural model compared after every clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_src_ctrl;

  localparam int DB      = 4;
  localparam int ALT_DIV = 8;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       ld0, ld1, btn_sel, auto_en;
  logic [7:0] I0, I1;
  logic       s, upd;

  mux2_src_ctrl #(
    .DB_CYCLES (DB),
    .ALT_DIV   (ALT_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .ld0     (ld0),
    .ld1     (ld1),
    .btn_sel (btn_sel),
    .auto_en (auto_en),
    .I0      (I0),
    .I1      (I1),
    .s       (s),
    .upd     (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int upd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model. Raw inputs reach the logic two edges late; a button
  // level is accepted once the last DB synchronized samples all disagree
  // with the accepted level; a rising acceptance acts one edge later.
  // --------------------------------------------------------------------------
  logic [7:0] m_i0, m_i1, m_sw_p1, m_sw_p2;
  logic       m_s, m_upd, m_auto, m_auto_p1, m_auto_p2;
  logic [2:0] m_btn_p1, m_btn_p2, m_lvl, m_pend;
  int         m_age;
  bit         m_win [3][$];

  task automatic model_step();
    logic [2:0] raw;
    logic [2:0] nxt;
    logic       tog;
    logic       any;
    bit         all_diff;
    raw = {btn_sel, ld1, ld0};
    if (rst) begin
      m_i0 = 8'h00; m_i1 = 8'h00; m_s = 1'b0; m_upd = 1'b0;
      m_sw_p1 = 8'h00; m_sw_p2 = 8'h00;
      m_auto = 1'b0; m_auto_p1 = 1'b0; m_auto_p2 = 1'b0;
      m_btn_p1 = 3'b000; m_btn_p2 = 3'b000; m_lvl = 3'b000; m_pend = 3'b000;
      m_age = 0;
      for (int b = 0; b < 3; b++) m_win[b].delete();
      return;
    end
    any = 1'b0;
    tog = 1'b0;
    if (m_pend[0]) begin m_i0 = m_sw_p2; any = 1'b1; end
    if (m_pend[1]) begin m_i1 = m_sw_p2; any = 1'b1; end
    if (!m_auto && m_pend[2]) tog = 1'b1;
    if (m_auto) begin
      if (m_auto_p2) begin
        m_age++;
        if (m_age % ALT_DIV == 0) tog = 1'b1;
      end
    end else begin
      m_age = 0;
    end
    m_auto = m_auto_p2;
    if (tog) m_s = ~m_s;
    m_upd = any | tog;
    for (int b = 0; b < 3; b++) begin
      m_win[b].push_back(m_btn_p2[b]);
      if (m_win[b].size() > DB) void'(m_win[b].pop_front());
      all_diff = (m_win[b].size() == DB);
      for (int j = 0; j < m_win[b].size(); j++)
        if (m_win[b][j] == m_lvl[b]) all_diff = 1'b0;
      nxt[b] = 1'b0;
      if (all_diff) begin
        m_lvl[b] = ~m_lvl[b];
        m_win[b].delete();
        nxt[b] = m_lvl[b];
      end
    end
    m_pend    = nxt;
    m_btn_p2  = m_btn_p1;
    m_btn_p1  = raw;
    m_sw_p2   = m_sw_p1;
    m_sw_p1   = sw;
    m_auto_p2 = m_auto_p1;
    m_auto_p1 = auto_en;
  endtask

  // One clock edge: advance the model, then compare outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_I0",  32'(I0),  32'(m_i0));
    check("model_I1",  32'(I1),  32'(m_i1));
    check("model_s",   32'(s),   32'(m_s));
    check("model_upd", 32'(upd), 32'(m_upd));
    if (upd) upd_seen++;
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] sw;
    logic       ld0, ld1, btn;
    int         hold;
    logic [7:0] e_i0, e_i1;
    logic       e_s;
    int         e_upd;
  } vec_t;

  vec_t vecs [8];

  task automatic apply_vec(input int k);
    sw = vecs[k].sw;
    upd_seen = 0;
    repeat (4) tick();
    ld0 = vecs[k].ld0; ld1 = vecs[k].ld1; btn_sel = vecs[k].btn;
    repeat (vecs[k].hold) tick();
    ld0 = 1'b0; ld1 = 1'b0; btn_sel = 1'b0;
    repeat (15) tick();
    check($sformatf("vec%0d_I0", k),  32'(I0),       32'(vecs[k].e_i0));
    check($sformatf("vec%0d_I1", k),  32'(I1),       32'(vecs[k].e_i1));
    check($sformatf("vec%0d_s", k),   32'(s),        32'(vecs[k].e_s));
    check($sformatf("vec%0d_upd", k), 32'(upd_seen), 32'(vecs[k].e_upd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_tog;
    logic       exp_upd;
    logic       s_hold;
    //            sw     ld0   ld1   btn  hold  I0     I1     s     upd
    vecs[0] = '{8'hAA, 1'b0, 1'b1, 1'b0, 10, 8'h55, 8'hAA, 1'b0, 1};
    vecs[1] = '{8'hAA, 1'b0, 1'b0, 1'b1, 10, 8'h55, 8'hAA, 1'b1, 1};
    vecs[2] = '{8'hAA, 1'b0, 1'b0, 1'b1, 10, 8'h55, 8'hAA, 1'b0, 1};
    vecs[3] = '{8'hAA, 1'b0, 1'b0, 1'b1, 10, 8'h55, 8'hAA, 1'b1, 1};
    vecs[4] = '{8'hAA, 1'b0, 1'b0, 1'b1, 50, 8'h55, 8'hAA, 1'b0, 1};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b0, 10, 8'h3C, 8'h3C, 1'b1, 1};
    vecs[6] = '{8'h0F, 1'b0, 1'b1, 1'b0, 10, 8'h3C, 8'h0F, 1'b1, 1};
    vecs[7] = '{8'h0F, 1'b0, 1'b1, 1'b0, 10, 8'h3C, 8'h0F, 1'b1, 1};

    rst = 1'b1; sw = 8'h00; ld0 = 1'b0; ld1 = 1'b0; btn_sel = 1'b0; auto_en = 1'b0;
    repeat (3) tick();
    check("rst_I0",  32'(I0),  32'h00);
    check("rst_I1",  32'(I1),  32'h00);
    check("rst_s",   32'(s),   32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    rst = 1'b0;

    // First load: output appears exactly 6 edges after capture.
    sw = 8'h55;
    repeat (4) tick();
    ld0 = 1'b1;
    tick();                       // capture edge t
    repeat (5) tick();            // t+5
    check("lat_I0_early",  32'(I0),  32'h00);
    check("lat_upd_early", 32'(upd), 32'h0);
    tick();                       // t+6
    check("lat_I0",  32'(I0),  32'h55);
    check("lat_upd", 32'(upd), 32'h1);
    check("lat_I1",  32'(I1),  32'h00);
    check("lat_s",   32'(s),   32'h0);
    tick();
    check("lat_upd_width", 32'(upd), 32'h0);
    ld0 = 1'b0;
    repeat (15) tick();

    // Bounce shorter than the debounce window: no effect.
    sw = 8'hAA;
    repeat (4) tick();
    upd_seen = 0;
    ld1 = 1'b1; repeat (2) tick();
    ld1 = 1'b0; repeat (2) tick();
    ld1 = 1'b1; repeat (3) tick();
    ld1 = 1'b0; repeat (15) tick();
    check("bounce_I1",  32'(I1),       32'h00);
    check("bounce_upd", 32'(upd_seen), 32'h0);

    for (int k = 0; k < 5; k++) apply_vec(k);

    // AUTO: toggles at edges 10,18,26,34,42 after capture; select presses
    // during AUTO are ignored.
    check("auto_s_start", 32'(s), 32'h0);
    auto_en = 1'b1;
    n_tog = 0;
    for (int c = 0; c <= 42; c++) begin
      btn_sel = ((c >= 12 && c < 17) || (c >= 26 && c < 31)) ? 1'b1 : 1'b0;
      tick();
      exp_upd = (c >= 10 && (c - 2) % ALT_DIV == 0) ? 1'b1 : 1'b0;
      if (exp_upd) n_tog++;
      check("auto_s",   32'(s),   32'(n_tog % 2));
      check("auto_upd", 32'(upd), 32'(exp_upd));
    end
    btn_sel = 1'b0;
    auto_en = 1'b0;
    upd_seen = 0;
    repeat (30) tick();
    check("freeze_s",   32'(s),        32'h1);
    check("freeze_upd", 32'(upd_seen), 32'h0);

    for (int k = 5; k < 8; k++) apply_vec(k);

    // Reset in the middle of a held load, then reload after normal latency.
    sw = 8'h3C;
    repeat (4) tick();
    ld0 = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    check("midrst_I0",  32'(I0),  32'h00);
    check("midrst_I1",  32'(I1),  32'h00);
    check("midrst_s",   32'(s),   32'h0);
    check("midrst_upd", 32'(upd), 32'h0);
    rst = 1'b0;
    tick();                       // capture edge t
    repeat (5) tick();
    check("reload_I0_early", 32'(I0), 32'h00);
    tick();
    check("reload_I0",  32'(I0),  32'h3C);
    check("reload_upd", 32'(upd), 32'h1);
    check("reload_I1",  32'(I1),  32'h00);
    ld0 = 1'b0;
    repeat (15) tick();

    // Randomized stimulus checked by the model every cycle.
    s_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0)   ld0     = ~ld0;
      if ($urandom_range(5) == 0)   ld1     = ~ld1;
      if ($urandom_range(5) == 0)   btn_sel = ~btn_sel;
      if ($urandom_range(149) == 0) auto_en = ~auto_en;
      if ($urandom_range(9) == 0)   sw      = 8'($urandom);
      rst = ($urandom_range(399) == 0) ? 1'b1 : 1'b0;
      tick();
      if (rst) begin
        check("rand_rst_upd", 32'(upd), 32'h0);
        s_hold = ~s_hold;
      end
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
